mem_bw_arbiter: RTL and testbench
=================================

MEM_BW_ARBITER -- requirements
Module: mem_bw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one memory address channel.
REQ-002 Parameter UTIL_COUNT_WIDTH (W), default 10, utilization fixed-point fraction width; utilization 2^W = 100%.
REQ-003 Parameter PAYLOAD_WIDTH, default 64, per-requester address-channel payload width.
REQ-004 Parameter WORK_CONSERVING, default 1; 1 = over-budget requesters may win when no in-budget requester is valid.
REQ-005 aclk  in  1  sole clock; all state on rising edge.
REQ-006 aresetn  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester address request valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-009 req_payload  in  NUM_REQ*PAYLOAD_WIDTH  packed payloads, requester i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
REQ-010 beat  in  NUM_REQ  one data beat completed (valid&&ready) for requester i this cycle.
REQ-011 budget  in  NUM_REQ*(W+1)  packed per-requester utilization ceiling; bit W set = unlimited.
REQ-012 out_valid  out  1  downstream address valid.
REQ-013 out_ready  in  1  downstream address ready.
REQ-014 out_payload  out  PAYLOAD_WIDTH  payload of granted requester.
REQ-015 out_grant  out  NUM_REQ  one-hot owner of out_valid; zero when idle.
REQ-016 utilization  out  NUM_REQ*(W+1)  packed per-requester utilization.

Function
REQ-017 Per requester i, a (2W+1)-bit counter c_i SHALL update each cycle: c_i + (beat[i]<<W) - (c_i>>W); no saturation required (steady-state maximum 2^(2W) fits).
REQ-018 utilization_i SHALL equal c_i[2W:W], registered (no combinational path from beat).
REQ-019 Requester i eligible SHALL be req_valid[i] && (budget_i[W] || utilization_i < budget_i).
REQ-020 If WORK_CONSERVING=1 and no requester is eligible, every valid requester SHALL be treated as eligible; if 0, none.
REQ-021 FSM states ARB and HOLD; reset state ARB.
REQ-022 ARB: if any eligible, register winner = first eligible index searching upward from (last_grant+1) mod NUM_REQ, go HOLD; else stay ARB.
REQ-023 HOLD: out_valid=1, out_grant=winner one-hot, out_payload=winner payload, req_ready[winner]=out_ready.
REQ-024 HOLD with out_ready=1: handshake completes, last_grant<=winner, go ARB; without it, stay HOLD.
REQ-025 out_grant, out_payload SHALL stay stable in HOLD until handshake, even if winner's utilization exceeds budget or budget changes.
REQ-026 ARB: out_valid=0, out_grant=0, req_ready=0; throughput one grant per two cycles maximum.
REQ-027 Requesters SHALL NOT deassert req_valid before req_ready; block does not check this.
REQ-028 budget SHALL be sampled only in ARB; changes mid-HOLD take effect at next arbitration.
REQ-029 beat for any requester SHALL be counted in every state, including during its own HOLD.

Reset
REQ-030 aresetn low SHALL asynchronously force: state=ARB, all c_i=0, last_grant=NUM_REQ-1 (first search starts at 0), out_valid=0, out_grant=0, req_ready=0, out_payload=0, utilization=0.
REQ-031 Reset asserted in HOLD SHALL abandon the grant with no handshake; deassertion SHALL be synchronized to aclk by the integrator.

Structure
REQ-032 Shared package mem_bw_pkg SHALL hold FSM state encoding (ARB=0, HOLD=1) and width helper (util field = W+1, counter = 2W+1).
REQ-033 Sub-module mem_bw_util_counter SHALL implement REQ-017/018 per requester, instantiated NUM_REQ times by generate.

Verification (NUM_REQ=4, W=4, PAYLOAD_WIDTH=8)
REQ-034 Reset, one beat[0] pulse -> next cycle utilization_0=1 (c_0=16); idle 1 cycle -> c_0=15, utilization_0=0.
REQ-035 beat[0] held high 200 cycles -> utilization_0 settles at 16, never exceeds 16, no wrap.
REQ-036 All req_valid=1, all budgets unlimited, out_ready=1 -> grants 0,1,2,3,0 each two cycles apart, out_payload matches.
REQ-037 budget_0=8, beat[0] continuous, req_valid 0 and 1 high -> once utilization_0>=8 only requester 1 granted; with req_valid[1]=0 and WORK_CONSERVING=1 requester 0 granted; with 0, out_valid stays 0.
REQ-038 Grant to requester 2, out_ready=0 10 cycles while budget_2 drops to 0 -> out_grant, out_payload unchanged; out_ready=1 -> single req_ready[2] pulse.
REQ-039 aresetn low mid-HOLD -> same-cycle out_valid=0, out_grant=0; after release first grant goes to lowest valid index.

Source files
------------

// File: rtl/mem_bw_pkg.sv
// Shared definitions for the memory bandwidth arbiter.
//   arb_state_t : arbiter FSM encoding (ARB = idle/arbitrating, HOLD = offer held)
//   util_width  : width of one utilization / budget field (W+1, bit W means 100%)
//   cnt_width   : width of the per-requester decaying beat counter (2W+1)
package mem_bw_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic int util_width(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mem_bw_arbiter_if.sv
// Bundle of requester-side and downstream address-channel signals.
//   master : the environment (requesters, downstream, budget source)
//   slave  : the arbiter
// Signals:
//   req_valid/req_ready/req_payload : per-requester address handshake
//   beat                            : per-requester completed data beat
//   budget/utilization              : per-requester ceiling / measured share
//   out_valid/out_ready/out_payload/out_grant : downstream address channel
interface mem_bw_arbiter_if
    import mem_bw_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int UTIL_COUNT_WIDTH = 10,
    parameter int PAYLOAD_WIDTH    = 64
);
    localparam int UW = util_width(UTIL_COUNT_WIDTH);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_payload;
    logic [NUM_REQ-1:0]               beat;
    logic [NUM_REQ*UW-1:0]            budget;
    logic                             out_valid;
    logic                             out_ready;
    logic [PAYLOAD_WIDTH-1:0]         out_payload;
    logic [NUM_REQ-1:0]               out_grant;
    logic [NUM_REQ*UW-1:0]            utilization;

    modport master (
        output req_valid, req_payload, beat, budget, out_ready,
        input  req_ready, out_valid, out_payload, out_grant, utilization
    );

    modport slave (
        input  req_valid, req_payload, beat, budget, out_ready,
        output req_ready, out_valid, out_payload, out_grant, utilization
    );

endinterface

// File: rtl/mem_bw_util_counter.sv
// Per-requester bandwidth utilization estimator: an exponentially decaying
// beat counter c <= c + (beat << W) - (c >> W). The integer part c[2W:W]
// is the utilization in units of 2^-W; it settles at exactly 2^W (100%)
// under a continuous beat, so 2W+1 bits never wrap.
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_beat        : one data beat completed this cycle
//   o_util        : registered utilization (W+1 bits)
module mem_bw_util_counter
    import mem_bw_pkg::*;
#(
    parameter int UTIL_COUNT_WIDTH = 10
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic                                      i_beat,
    output logic [util_width(UTIL_COUNT_WIDTH)-1:0]   o_util
);
    localparam int W  = UTIL_COUNT_WIDTH;
    localparam int CW = cnt_width(W);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + (CW'(i_beat) << W) - (r_cnt >> W);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Taken straight from the counter register, so beat never reaches
    // utilization combinationally.
    assign o_util = r_cnt[2*W:W];

endmodule

// File: rtl/mem_bw_arbiter.sv
// Round-robin address-channel arbiter with per-requester bandwidth budgets.
// A requester is eligible while its measured utilization is below its
// budget (or the budget is unlimited). With WORK_CONSERVING=1 all valid
// requesters become eligible when none is within budget. A winner is
// registered in ARB and held in HOLD until the downstream handshake.
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : mem_bw_arbiter_if slave modport (requests, beats,
//                   budgets, downstream channel, utilization)
module mem_bw_arbiter
    import mem_bw_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int UTIL_COUNT_WIDTH = 10,
    parameter int PAYLOAD_WIDTH    = 64,
    parameter int WORK_CONSERVING  = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    mem_bw_arbiter_if.slave bus
);
    localparam int UW    = util_width(UTIL_COUNT_WIDTH);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [UW-1:0]            w_util    [NUM_REQ];
    logic [UW-1:0]            w_budget  [NUM_REQ];
    logic [PAYLOAD_WIDTH-1:0] w_payload [NUM_REQ];
    logic [NUM_REQ*UW-1:0]    w_util_flat;
    logic [NUM_REQ-1:0]       w_in_budget;
    logic [NUM_REQ-1:0]       w_elig_strict;
    logic [NUM_REQ-1:0]       w_elig;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            mem_bw_util_counter #(
                .UTIL_COUNT_WIDTH (UTIL_COUNT_WIDTH)
            ) u_cnt (
                .aclk    (aclk),
                .aresetn (aresetn),
                .i_beat  (bus.beat[gi]),
                .o_util  (w_util[gi])
            );
            assign w_util_flat[gi*UW +: UW] = w_util[gi];
            assign w_budget[gi]  = bus.budget[gi*UW +: UW];
            assign w_payload[gi] = bus.req_payload[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            // Top budget bit means unlimited.
            assign w_in_budget[gi]   = w_budget[gi][UW-1] || (w_util[gi] < w_budget[gi]);
            assign w_elig_strict[gi] = bus.req_valid[gi] && w_in_budget[gi];
        end
    endgenerate

    assign bus.utilization = w_util_flat;

    // Fall back to plain valid only when nobody is within budget.
    assign w_elig = (|w_elig_strict) ? w_elig_strict
                  : ((WORK_CONSERVING != 0) ? bus.req_valid : '0);

    // Round-robin search starting just above the last completed grant.
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_last_grant;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // FSM: state register plus next-state/output logic.
    arb_state_t               r_state, w_state_next;
    logic [IDX_W-1:0]         r_winner, w_winner_next;
    logic [IDX_W-1:0]         w_last_grant_next;
    logic [PAYLOAD_WIDTH-1:0] r_payload, w_payload_next;
    logic                     w_out_valid;
    logic [NUM_REQ-1:0]       w_grant;
    logic [NUM_REQ-1:0]       w_req_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ARB;
            r_winner     <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_payload    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_winner     <= w_winner_next;
            r_last_grant <= w_last_grant_next;
            r_payload    <= w_payload_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_winner_next     = r_winner;
        w_last_grant_next = r_last_grant;
        w_payload_next    = r_payload;
        w_out_valid       = 1'b0;
        w_grant           = '0;
        w_req_ready       = '0;
        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_winner_next  = w_pick;
                    // Captured so the offer cannot move while held.
                    w_payload_next = w_payload[w_pick];
                    w_state_next   = HOLD;
                end
            end
            HOLD: begin
                w_out_valid       = 1'b1;
                w_grant[r_winner] = 1'b1;
                if (bus.out_ready) begin
                    w_req_ready[r_winner] = 1'b1;
                    w_last_grant_next     = r_winner;
                    w_state_next          = ARB;
                end
            end
            default: w_state_next = ARB;
        endcase
    end

    assign bus.out_valid   = w_out_valid;
    assign bus.out_grant   = w_grant;
    assign bus.req_ready   = w_req_ready;
    assign bus.out_payload = r_payload;

endmodule

// File: tb/tb_mem_bw_arbiter.sv
// Directed bench for mem_bw_arbiter (NUM_REQ=4, W=4, PAYLOAD_WIDTH=8).
// Two instances share stimulus: u_dut (work-conserving) and u_dut_nc
// (non-work-conserving), the latter checked only where they differ.
module tb_mem_bw_arbiter;
    import mem_bw_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int PW = 8;
    localparam int UW = W + 1;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    mem_bw_arbiter_if #(.NUM_REQ(N), .UTIL_COUNT_WIDTH(W), .PAYLOAD_WIDTH(PW)) if0 ();
    mem_bw_arbiter_if #(.NUM_REQ(N), .UTIL_COUNT_WIDTH(W), .PAYLOAD_WIDTH(PW)) if1 ();

    assign if1.req_valid   = if0.req_valid;
    assign if1.req_payload = if0.req_payload;
    assign if1.beat        = if0.beat;
    assign if1.budget      = if0.budget;
    assign if1.out_ready   = if0.out_ready;

    mem_bw_arbiter #(
        .NUM_REQ(N), .UTIL_COUNT_WIDTH(W), .PAYLOAD_WIDTH(PW), .WORK_CONSERVING(1)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .bus(if0)
    );

    mem_bw_arbiter #(
        .NUM_REQ(N), .UTIL_COUNT_WIDTH(W), .PAYLOAD_WIDTH(PW), .WORK_CONSERVING(0)
    ) u_dut_nc (
        .aclk(aclk), .aresetn(aresetn), .bus(if1)
    );

    typedef struct {
        logic          beat0;
        logic [UW-1:0] exp_util0;
    } cnt_vec_t;

    cnt_vec_t        cvec [8];
    logic [PW-1:0]   pay  [N];
    logic [UW-1:0]   unl;
    logic [N*UW-1:0] unl_all;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [UW-1:0] util_of(input int i);
        return if0.utilization[i*UW +: UW];
    endfunction

    initial begin
        // Hand-computed counter trace from reset, W=4.
        // c: 16,15,31,46,60,57,54,67 -> util = c>>4
        cvec[0] = '{1'b1, 5'd1};
        cvec[1] = '{1'b0, 5'd0};
        cvec[2] = '{1'b1, 5'd1};
        cvec[3] = '{1'b1, 5'd2};
        cvec[4] = '{1'b1, 5'd3};
        cvec[5] = '{1'b0, 5'd3};
        cvec[6] = '{1'b0, 5'd3};
        cvec[7] = '{1'b1, 5'd4};

        pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2; pay[3] = 8'hD3;
        unl     = 5'b10000;
        unl_all = {N{unl}};

        if0.req_valid   = '0;
        if0.req_payload = {pay[3], pay[2], pay[1], pay[0]};
        if0.beat        = '0;
        if0.budget      = unl_all;
        if0.out_ready   = 1'b0;

        // Reset state
        aresetn = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_out_grant", 32'(if0.out_grant), 32'd0);
        check("rst_req_ready", 32'(if0.req_ready), 32'd0);
        check("rst_out_payload", 32'(if0.out_payload), 32'd0);
        check("rst_utilization", 32'(if0.utilization), 32'd0);
        aresetn = 1'b1;
        step();
        check("idle_out_valid", 32'(if0.out_valid), 32'd0);

        // Counter trace
        for (int v = 0; v < 8; v++) begin
            if0.beat = {3'b000, cvec[v].beat0};
            step();
            check($sformatf("util0_vec%0d", v), 32'(util_of(0)), 32'(cvec[v].exp_util0));
        end
        check("util1_untouched", 32'(util_of(1)), 32'd0);

        // Continuous beat: settles at 100% without overshoot or wrap
        if0.beat = 4'b0001;
        for (int c = 0; c < 200; c++) begin
            step();
            check($sformatf("util0_le16_c%0d", c), 32'(util_of(0) <= 5'd16), 32'd1);
        end
        check("util0_settled", 32'(util_of(0)), 32'd16);

        // Round robin with unlimited budgets
        if0.req_valid = 4'b1111;
        if0.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr%0d_valid", k), 32'(if0.out_valid), 32'd1);
            check($sformatf("rr%0d_grant", k), 32'(if0.out_grant), 32'(4'b0001 << (k % 4)));
            check($sformatf("rr%0d_payload", k), 32'(if0.out_payload), 32'(pay[k % 4]));
            check($sformatf("rr%0d_ready", k), 32'(if0.req_ready), 32'(4'b0001 << (k % 4)));
            step();
            check($sformatf("rr%0d_gap", k), 32'(if0.out_valid), 32'd0);
        end

        // Requester 0 over budget (util 16 >= 8): only requester 1 wins
        if0.budget[0 +: UW] = 5'd8;
        if0.req_valid = 4'b0011;
        check("bud_util0", 32'(util_of(0)), 32'd16);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bud%0d_grant_wc", k), 32'(if0.out_grant), 32'b0010);
            check($sformatf("bud%0d_grant_nc", k), 32'(if1.out_grant), 32'b0010);
            step();
            check($sformatf("bud%0d_gap", k), 32'(if0.out_valid | if1.out_valid), 32'd0);
        end

        // Only over-budget requester valid
        if0.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("wc%0d_grant", k), 32'(if0.out_grant), 32'b0001);
            check($sformatf("nc%0d_valid_a", k), 32'(if1.out_valid), 32'd0);
            step();
            check($sformatf("nc%0d_valid_b", k), 32'(if1.out_valid), 32'd0);
        end
        if0.req_valid = 4'b0000;
        if0.beat      = 4'b0000;
        step();
        step();

        // Held grant is stable while downstream stalls and budget collapses
        if0.budget    = unl_all;
        if0.req_valid = 4'b0100;
        if0.out_ready = 1'b0;
        step();
        check("hold_grant0", 32'(if0.out_grant), 32'b0100);
        check("hold_payload0", 32'(if0.out_payload), 32'(pay[2]));
        if0.budget[2*UW +: UW] = 5'd0;
        if0.beat = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("hold%0d_grant", c), 32'(if0.out_grant), 32'b0100);
            check($sformatf("hold%0d_payload", c), 32'(if0.out_payload), 32'(pay[2]));
            check($sformatf("hold%0d_ready", c), 32'(if0.req_ready), 32'd0);
        end
        check("hold_util2_rising", 32'(util_of(2) != 5'd0), 32'd1);
        if0.out_ready = 1'b1;
        #1;
        check("hold_ready_pulse", 32'(if0.req_ready), 32'b0100);
        step();
        if0.req_valid = 4'b0000;
        check("hold_ready_after", 32'(if0.req_ready), 32'd0);
        check("hold_valid_after", 32'(if0.out_valid), 32'd0);
        step();
        check("hold_ready_after2", 32'(if0.req_ready), 32'd0);

        // Reset asserted while holding a grant to requester 3
        if0.budget    = unl_all;
        if0.beat      = 4'b0000;
        if0.req_valid = 4'b1000;
        if0.out_ready = 1'b0;
        step();
        check("pre_rst_grant", 32'(if0.out_grant), 32'b1000);
        if0.req_valid = 4'b1010;
        aresetn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(if0.out_valid), 32'd0);
        check("midrst_out_grant", 32'(if0.out_grant), 32'd0);
        check("midrst_req_ready", 32'(if0.req_ready), 32'd0);
        check("midrst_payload", 32'(if0.out_payload), 32'd0);
        check("midrst_util", 32'(if0.utilization), 32'd0);
        step();
        aresetn = 1'b1;
        if0.out_ready = 1'b1;
        step();
        check("postrst_grant", 32'(if0.out_grant), 32'b0010);
        check("postrst_payload", 32'(if0.out_payload), 32'(pay[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
